// File: rtl/mmio_apu_regs.sv
// mmio_apu_regs: MMIO register block for the APU (control, sample tick divider, channel config, command FIFO)
module mmio_apu_regs #(
  parameter logic [7:0] BASE       = 8'h09,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  s_addr,
  input  logic         s_en,
  input  logic         s_we,
  input  logic [31:0]  s_wdata,
  output logic [31:0]  s_rdata,
  output logic         apu_enable,
  output logic         tick,
  output logic [127:0] ch_cfg,
  output logic         cmd_valid,
  output logic [31:0]  cmd_data,
  input  logic         cmd_ready,
  output logic         irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [1:0]        r_ctrl;
  logic              r_irq_pend, r_ovf;
  logic [15:0]       r_tick_div, r_div_cnt;
  logic [31:0]       r_tick_cnt, r_rdata;
  logic [3:0][31:0]  r_ch_cfg;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_acc, w_wr, w_rd, w_st, w_tick, w_pop, w_push_req, w_push, w_unused;
  logic [5:0]        w_off;
  logic [31:0]       w_rd_val;
  assign w_acc      = s_en && s_addr[31:24] == BASE;
  assign w_wr       = w_acc && s_we;
  assign w_rd       = w_acc && !s_we;
  assign w_off      = s_addr[7:2];
  assign w_st       = w_wr && w_off == 6'h01;
  assign w_tick     = r_ctrl[0] && r_div_cnt == r_tick_div;
  assign w_pop      = cmd_valid && cmd_ready;
  assign w_push_req = w_wr && w_off == 6'h04;
  // count is at most FIFO_DEPTH, so its MSB alone marks full
  assign w_push     = w_push_req && (!r_count[AW] || w_pop);
  assign w_unused   = ^{s_addr[23:8], s_addr[1:0]};
  assign s_rdata    = r_rdata;
  assign apu_enable = r_ctrl[0];
  assign tick       = w_tick;
  assign ch_cfg     = r_ch_cfg;
  assign irq        = r_irq_pend && r_ctrl[1];
  assign cmd_valid  = r_count != '0;
  assign cmd_data   = r_mem[r_rd_ptr];
  always_comb begin
    w_rd_val = '0;
    case (w_off)
      6'h00:                      w_rd_val = {30'b0, r_ctrl};
      6'h01:                      w_rd_val = {16'b0, 8'(r_count), 6'b0, r_ovf, r_irq_pend};
      6'h02:                      w_rd_val = {16'b0, r_tick_div};
      6'h03:                      w_rd_val = r_tick_cnt;
      6'h08, 6'h09, 6'h0A, 6'h0B: w_rd_val = r_ch_cfg[w_off[1:0]];
      default:                    w_rd_val = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_irq_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_tick_div <= '0;
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_ch_cfg   <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_rd) r_rdata <= w_rd_val;
      if (w_wr && w_off == 6'h00) r_ctrl <= s_wdata[1:0];
      if (w_wr && w_off == 6'h02) r_tick_div <= s_wdata[15:0];
      if (w_wr && w_off[5:2] == 4'h2) r_ch_cfg[w_off[1:0]] <= s_wdata;
      // sticky flags: a same-cycle set beats the write-one-to-clear
      r_irq_pend <= (w_tick && r_ctrl[1]) || (r_irq_pend && !(w_st && s_wdata[0]));
      r_ovf      <= (w_push_req && !w_push) || (r_ovf && !(w_st && s_wdata[1]));
      r_div_cnt  <= (!r_ctrl[0] || w_tick || (w_wr && w_off == 6'h02)) ? '0 : r_div_cnt + 16'd1;
      if (w_tick) r_tick_cnt <= r_tick_cnt + 32'd1;
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_wdata;
  end
endmodule

// File: tb/tb_mmio_apu_regs.sv
// tb_mmio_apu_regs: directed bench for mmio_apu_regs with hand-computed expectations
module tb_mmio_apu_regs;
  logic         clk, rst, s_en, s_we, cmd_ready;
  logic [31:0]  s_addr, s_wdata, s_rdata, cmd_data;
  logic [127:0] ch_cfg;
  logic         apu_enable, tick, cmd_valid, irq;
  int checks = 0;
  int errors = 0;
  mmio_apu_regs #(.BASE(8'h09), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .s_addr(s_addr), .s_en(s_en), .s_we(s_we), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .apu_enable(apu_enable), .tick(tick), .ch_cfg(ch_cfg),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .irq(irq)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    s_en = 1'b1; s_we = 1'b1; s_addr = a; s_wdata = d;
    @(negedge clk);
    s_en = 1'b0; s_we = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    s_en = 1'b1; s_we = 1'b0; s_addr = a;
    @(negedge clk);
    s_en = 1'b0;
    chk(tag, {96'b0, s_rdata}, {96'b0, exp});
  endtask
  initial begin
    rst = 1'b1; s_en = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0; cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdata", {96'b0, s_rdata}, 128'h0);
    chk("rst_chcfg", ch_cfg, 128'h0);
    chk("rst_outs", {124'b0, tick, cmd_valid, irq, apu_enable}, 128'h0);
    wr(32'h09000020, 32'hDEADBEEF);
    chk("chcfg0_out", {96'b0, ch_cfg[31:0]}, {96'b0, 32'hDEADBEEF});
    rd_chk("chcfg0_rd", 32'h09000020, 32'hDEADBEEF);
    rd_chk("chcfg0_rd_lowbits", 32'h09000023, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    chk("rdata_hold_idle", {96'b0, s_rdata}, {96'b0, 32'hDEADBEEF});
    rd_chk("bad_base_rd_hold", 32'h06000020, 32'hDEADBEEF);
    rd_chk("unmapped_rd", 32'h09000040, 32'h0);
    wr(32'h0900002C, 32'h12345678);
    chk("chcfg3_out", {96'b0, ch_cfg[127:96]}, {96'b0, 32'h12345678});
    wr(32'h09000008, 32'hABCD1234);
    rd_chk("tickdiv_rd", 32'h09000008, 32'h00001234);
    wr(32'h0900000C, 32'h55555555);
    rd_chk("tickcnt_ro", 32'h0900000C, 32'h0);
    wr(32'h06000000, 32'hFFFFFFFF);
    wr(32'h06000020, 32'h0);
    chk("bad_base_ctrl", {127'b0, apu_enable}, 128'h0);
    chk("bad_base_chcfg", {96'b0, ch_cfg[31:0]}, {96'b0, 32'hDEADBEEF});
    rd_chk("bad_base_ctrl_rd", 32'h09000000, 32'h0);
    // divider 3: counter 0..3, tick when it hits 3
    wr(32'h09000008, 32'd3);
    wr(32'h09000000, 32'd3);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("tick_k%0d", k), {127'b0, tick}, {127'b0, (k % 4 == 0)});
      chk($sformatf("irq_k%0d", k), {127'b0, irq}, {127'b0, (k >= 5)});
      @(negedge clk);
    end
    repeat (11) @(negedge clk);
    rd_chk("tickcnt_20cyc", 32'h0900000C, 32'd5);
    for (int i = 0; i < 8 && tick !== 1'b1; i++) @(negedge clk);
    chk("tick_seen", {127'b0, tick}, {127'b0, 1'b1});
    s_en = 1'b1; s_we = 1'b1; s_addr = 32'h09000004; s_wdata = 32'd1;
    @(negedge clk);
    chk("irq_set_beats_w1c", {127'b0, irq}, {127'b0, 1'b1});
    @(negedge clk);
    s_en = 1'b0; s_we = 1'b0;
    chk("irq_w1c", {127'b0, irq}, 128'h0);
    wr(32'h09000000, 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("tick_off_%0d", k), {127'b0, tick}, 128'h0);
      @(negedge clk);
    end
    rd_chk("tickcnt_hold", 32'h0900000C, 32'd6);
    rd_chk("status_clear", 32'h09000004, 32'h0);
    wr(32'h09000008, 32'd0);
    wr(32'h09000000, 32'd1);
    chk("div0_tick_a", {127'b0, tick}, {127'b0, 1'b1});
    @(negedge clk);
    chk("div0_tick_b", {127'b0, tick}, {127'b0, 1'b1});
    @(negedge clk);
    chk("div0_tick_c", {127'b0, tick}, {127'b0, 1'b1});
    wr(32'h09000000, 32'd0);
    chk("div0_off", {127'b0, tick}, 128'h0);
    rd_chk("div0_tickcnt", 32'h0900000C, 32'd10);
    for (int i = 1; i <= 9; i++) wr(32'h09000010, i);
    chk("fifo_valid", {127'b0, cmd_valid}, {127'b0, 1'b1});
    chk("fifo_head", {96'b0, cmd_data}, 128'd1);
    rd_chk("fifo_data_rd", 32'h09000010, 32'h0);
    // pop and STATUS read in the same cycle: count seen before the pop
    @(negedge clk);
    cmd_ready = 1'b1; s_en = 1'b1; s_we = 1'b0; s_addr = 32'h09000004;
    chk("fifo_pop_1", {96'b0, cmd_data}, 128'd1);
    @(negedge clk);
    s_en = 1'b0;
    chk("status_full_ovf", {96'b0, s_rdata}, {96'b0, 32'h00000802});
    for (int i = 2; i <= 8; i++) begin
      chk($sformatf("fifo_pop_%0d", i), {95'b0, cmd_valid, cmd_data}, {95'b0, 1'b1, 32'(i)});
      @(negedge clk);
    end
    chk("fifo_empty", {127'b0, cmd_valid}, 128'h0);
    cmd_ready = 1'b0;
    wr(32'h09000004, 32'd2);
    rd_chk("ovf_w1c", 32'h09000004, 32'h0);
    for (int i = 0; i < 8; i++) wr(32'h09000010, 32'h10 + i);
    @(negedge clk);
    cmd_ready = 1'b1; s_en = 1'b1; s_we = 1'b1; s_addr = 32'h09000010; s_wdata = 32'hA5;
    @(negedge clk);
    cmd_ready = 1'b0; s_en = 1'b0; s_we = 1'b0;
    rd_chk("full_pushpop_status", 32'h09000004, 32'h00000800);
    @(negedge clk);
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("full_drain_%0d", i), {96'b0, cmd_data}, {96'b0, (i < 7) ? 32'h11 + i : 32'hA5});
      @(negedge clk);
    end
    chk("full_drain_empty", {127'b0, cmd_valid}, 128'h0);
    cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(32'h09000010, 32'h30 + i);
    wr(32'h09000000, 32'd3);
    @(negedge clk);
    chk("pre_rst_irq", {127'b0, irq}, {127'b0, 1'b1});
    chk("pre_rst_valid", {127'b0, cmd_valid}, {127'b0, 1'b1});
    rst = 1'b1; s_en = 1'b1; s_we = 1'b1; s_addr = 32'h09000020; s_wdata = 32'h5555AAAA;
    @(negedge clk);
    rst = 1'b0; s_en = 1'b0; s_we = 1'b0;
    chk("mid_rst_outs", {124'b0, tick, cmd_valid, irq, apu_enable}, 128'h0);
    chk("mid_rst_chcfg", ch_cfg, 128'h0);
    chk("mid_rst_rdata", {96'b0, s_rdata}, 128'h0);
    rd_chk("mid_rst_status", 32'h09000004, 32'h0);
    rd_chk("mid_rst_tickcnt", 32'h0900000C, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmio_apu_regs.md
MMIO_APU_REGS -- requirements
Module: mmio_apu_regs

Interface
REQ-001 SHALL have parameter BASE, default 8'h09: s_addr[31:24] value this slave responds to.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: command FIFO entries (power of two, 2..64).
REQ-003 SHALL have ports: clk  in  1  sole clock (one clock, all logic on rising edge).
REQ-004 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: s_addr  in  32  bus address from MMIO decoder slave port.
REQ-006 SHALL have ports: s_en  in  1  bus access strobe, one cycle per access.
REQ-007 SHALL have ports: s_we  in  1  1=write, 0=read, qualified by s_en.
REQ-008 SHALL have ports: s_wdata  in  32  write data.
REQ-009 SHALL have ports: s_rdata  out  32  read data.
REQ-010 SHALL have ports: apu_enable  out  1  CTRL[0].
REQ-011 SHALL have ports: tick  out  1  one-cycle sample tick pulse.
REQ-012 SHALL have ports: ch_cfg  out  128  CH_CFG[3..0], channel n at bits [32n+31:32n].
REQ-013 SHALL have ports: cmd_valid  out  1, cmd_data  out  32, cmd_ready  in  1  command stream to APU core.
REQ-014 SHALL have ports: irq  out  1  interrupt request.

Function
REQ-015 SHALL accept an access only when s_en=1 and s_addr[31:24]==BASE; register offset = s_addr[7:0], s_addr[1:0] ignored.
REQ-016 SHALL implement the map: 0x00 CTRL (RW, bit0 enable, bit1 irq_en); 0x04 STATUS (bit0 irq_pending W1C, bit1 overflow W1C, bits[15:8] fifo count RO); 0x08 TICK_DIV (RW, bits[15:0]); 0x0C TICK_CNT (RO); 0x10 FIFO_DATA (WO, push); 0x20/0x24/0x28/0x2C CH_CFG0..3 (RW, 32-bit).
REQ-017 SHALL register read data: s_rdata valid on the cycle after an accepted read and held until the next accepted read.
REQ-018 SHALL return 0 for reads of unmapped offsets and of FIFO_DATA; writes to unmapped or RO offsets have no effect.
REQ-019 SHALL return unimplemented register bits as 0.
REQ-020 SHALL run a 16-bit divider counter only while CTRL[0]=1; when it equals TICK_DIV it wraps to 0, tick pulses 1 cycle and TICK_CNT increments (32-bit, wraps 0xFFFFFFFF->0).
REQ-021 SHALL produce a tick every cycle when TICK_DIV=0; clearing CTRL[0] resets the divider counter to 0 and suppresses tick; TICK_CNT holds.
REQ-022 SHALL reset the divider counter to 0 on any TICK_DIV write.
REQ-023 SHALL set irq_pending on a tick when CTRL[1]=1; set wins over a same-cycle W1C.
REQ-024 SHALL drive irq = irq_pending & CTRL[1], registered-state combinational.
REQ-025 SHALL push s_wdata into the FIFO on a FIFO_DATA write when count<FIFO_DEPTH or a pop occurs the same cycle.
REQ-026 SHALL otherwise drop the word and set overflow (sticky, same-cycle set wins over W1C).
REQ-027 SHALL drive cmd_valid=1 iff count>0, cmd_data = oldest entry (first-word-fall-through), pop when cmd_valid & cmd_ready.
REQ-028 SHALL hold cmd_data stable while cmd_valid=1 and cmd_ready=0.
REQ-029 SHALL adjust count: push only +1, pop only -1, both unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-030 SHALL read STATUS count as the pre-update value of the read cycle.

Reset
REQ-031 SHALL on rst=1 clear CTRL, STATUS flags, TICK_DIV, TICK_CNT, divider counter, CH_CFG0..3, FIFO pointers/count and s_rdata to 0; outputs tick, cmd_valid, irq, apu_enable = 0, ch_cfg = 0.
REQ-032 SHALL let rst override any same-cycle access; FIFO contents discarded mid-stream; cmd_data is don't-care while cmd_valid=0.

Verification
REQ-033 SHALL cover: write 0x09000020=0xDEADBEEF, read it -> s_rdata=0xDEADBEEF next cycle, ch_cfg[31:0]=0xDEADBEEF; read 0x09000040 -> 0.
REQ-034 SHALL cover: TICK_DIV=3, CTRL=3 -> tick every 4 cycles, TICK_CNT=5 after 20 cycles from enable, irq=1 after first tick; W1C STATUS=1 coincident with a tick -> irq stays 1.
REQ-035 SHALL cover: cmd_ready=0, 9 writes to FIFO_DATA (values 1..9) -> count=8, overflow=1, cmd_valid=1, cmd_data=1; then cmd_ready=1 -> pops 1..8 in order, cmd_valid=0 after.
REQ-036 SHALL cover: FIFO full with cmd_ready=1, write 0xA5 -> accepted, count stays 8, overflow stays 0.
REQ-037 SHALL cover: access with s_addr=0x06000000, s_en=1, s_we=1 -> no register changes.
REQ-038 SHALL cover: rst asserted with 3 FIFO entries and CTRL=3 -> next cycle all outputs 0, STATUS reads 0.
